// File: rtl/dma_int_pkg.sv
// Shared definitions for the DMA interrupt event presenter:
// flag bit positions, flag width and FSM state encoding.
package dma_int_pkg;

  localparam int FLAG_WIDTH = 4;

  localparam int FLG_DONE         = 0;
  localparam int FLG_WR_ERR       = 1;
  localparam int FLG_RD_ERR       = 2;
  localparam int FLG_INVALID_DESC = 3;

  typedef logic [1:0] stateT;

  localparam stateT ST_IDLE    = 2'd0;
  localparam stateT ST_POP     = 2'd1;
  localparam stateT ST_CAP     = 2'd2;
  localparam stateT ST_PRESENT = 2'd3;

  // A flag survives only if software has enabled it in the mask.
  function automatic logic [FLAG_WIDTH-1:0] maskFlags(
    input logic [FLAG_WIDTH-1:0] rawFlags,
    input logic [FLAG_WIDTH-1:0] mask
  );
    return rawFlags & mask;
  endfunction

endpackage

// File: rtl/dma_int_sat_counter.sv
// Saturating up-counter with a clear input that wins over a
// same-cycle increment. Used to count events discarded by the mask.
module dma_int_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; otherwise count up until all-ones and stick there.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dma_int_event_presenter.sv
// Pops DMA interrupt events from the event FIFO one at a time, filters
// them against the interrupt mask and presents unmasked events to
// software through a held status register and a level irq.
module dma_int_event_presenter #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FLAG_WIDTH     = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           fifoEmpty,
  input  logic [FIFO_WIDTH-1:0]          fifoRdData,
  input  logic                           fifoDbErr,
  output logic                           fifoRdEn,
  input  logic [FLAG_WIDTH-1:0]          intMask,
  input  logic                           intClr,
  input  logic                           dropCntClr,
  output logic                           irq,
  output logic                           statusValid,
  output logic [FIFO_WIDTH-FLAG_WIDTH-1:0] statusDesc,
  output logic [FLAG_WIDTH-1:0]          statusFlags,
  output logic [DROP_CNT_WIDTH-1:0]      dropCnt,
  output logic                           eccErr
);

  import dma_int_pkg::*;

  // The flag layout in the event word is fixed; refuse any other width.
  if (FLAG_WIDTH != dma_int_pkg::FLAG_WIDTH) begin : gFlagWidthCheck
    $error("dma_int_event_presenter: FLAG_WIDTH must be 4");
  end

  stateT                   state;
  logic [FLAG_WIDTH-1:0]   rawFlags;
  logic [FLAG_WIDTH-1:0]   maskedFlags;
  logic                    dropInc;

  assign rawFlags    = fifoRdData[FLAG_WIDTH-1:0];
  assign maskedFlags = maskFlags(rawFlags, intMask);
  assign dropInc     = (state == ST_CAP) && (maskedFlags == '0);

  // Event sequencing: sample FIFO, pop, capture/filter, then hold until cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      fifoRdEn    <= 1'b0;
      irq         <= 1'b0;
      statusValid <= 1'b0;
      statusDesc  <= '0;
      statusFlags <= '0;
      eccErr      <= 1'b0;
    end else begin
      fifoRdEn <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            state    <= ST_POP;
            fifoRdEn <= 1'b1;
          end
        end
        ST_POP: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          if (fifoDbErr) begin
            eccErr <= 1'b1;
          end
          if (maskedFlags != '0) begin
            statusDesc  <= fifoRdData[FIFO_WIDTH-1:FLAG_WIDTH];
            statusFlags <= maskedFlags;
            statusValid <= 1'b1;
            irq         <= 1'b1;
            state       <= ST_PRESENT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (intClr) begin
            statusDesc  <= '0;
            statusFlags <= '0;
            statusValid <= 1'b0;
            irq         <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dma_int_sat_counter #(
    .WIDTH(DROP_CNT_WIDTH)
  ) uDropCounter (
    .clock(clock),
    .reset(reset),
    .clr  (dropCntClr),
    .inc  (dropInc),
    .count(dropCnt)
  );

endmodule

// File: tb/tb_dma_int_event_presenter.sv
// Directed bench for dma_int_event_presenter with a behavioural event FIFO.
module tb_dma_int_event_presenter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifoEmpty;
  logic [7:0] fifoRdData = 8'h00;
  logic       fifoDbErr = 1'b0;
  logic       fifoRdEn;
  logic [3:0] intMask = 4'h0;
  logic       intClr = 1'b0;
  logic       dropCntClr = 1'b0;
  logic       irq;
  logic       statusValid;
  logic [3:0] statusDesc;
  logic [3:0] statusFlags;
  logic [7:0] dropCnt;
  logic       eccErr;

  logic [8:0] fifoMem [0:1023];
  int         wrPtr = 0;
  int         rdPtr = 0;

  int compareCount  = 0;
  int mismatchCount = 0;

  dma_int_event_presenter #(
    .FIFO_WIDTH(8),
    .FLAG_WIDTH(4),
    .DROP_CNT_WIDTH(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fifoEmpty  (fifoEmpty),
    .fifoRdData (fifoRdData),
    .fifoDbErr  (fifoDbErr),
    .fifoRdEn   (fifoRdEn),
    .intMask    (intMask),
    .intClr     (intClr),
    .dropCntClr (dropCntClr),
    .irq        (irq),
    .statusValid(statusValid),
    .statusDesc (statusDesc),
    .statusFlags(statusFlags),
    .dropCnt    (dropCnt),
    .eccErr     (eccErr)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  assign fifoEmpty = (wrPtr == rdPtr);

  // FIFO model: data and ECC flag appear the cycle after a pop strobe.
  always @(posedge clock) begin
    if (fifoRdEn) begin
      {fifoDbErr, fifoRdData} <= fifoMem[rdPtr % 1024];
      rdPtr <= rdPtr + 1;
    end
  end

  // Hard stop in case a wait is ever unbounded.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic dbErr);
    fifoMem[wrPtr % 1024] = {dbErr, data};
    wrPtr++;
  endtask

  task automatic waitIrq(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (irq !== 1'b1 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    if (irq !== 1'b1) checkOutput({tag, "_timeout"}, {31'd0, irq}, 32'd1);
  endtask

  task automatic pulseClr();
    intClr = 1'b1;
    @(negedge clock);
    intClr = 1'b0;
  endtask

  int           cycles;
  logic         irqSeen;
  logic [7:0]   b2bEvents [3];
  logic [3:0]   b2bDesc   [3];
  logic [3:0]   b2bFlags  [3];

  // Directed sequence.
  initial begin
    b2bEvents = '{8'h11, 8'h22, 8'h38};
    b2bDesc   = '{4'h1, 4'h2, 4'h3};
    b2bFlags  = '{4'h1, 4'h2, 4'h8};

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_valid", {31'd0, statusValid}, 32'd0);
    checkOutput("rst_desc", {28'd0, statusDesc}, 32'd0);
    checkOutput("rst_flags", {28'd0, statusFlags}, 32'd0);
    checkOutput("rst_drop", {24'd0, dropCnt}, 32'd0);
    checkOutput("rst_ecc", {31'd0, eccErr}, 32'd0);
    checkOutput("rst_rden", {31'd0, fifoRdEn}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single event 0x51, all flags enabled
    intMask = 4'hF;
    applyStimulus(8'h51, 1'b0);
    @(negedge clock);
    checkOutput("single_rden_pulse", {31'd0, fifoRdEn}, 32'd1);
    checkOutput("single_irq_c1", {31'd0, irq}, 32'd0);
    @(negedge clock);
    checkOutput("single_rden_low", {31'd0, fifoRdEn}, 32'd0);
    checkOutput("single_irq_c2", {31'd0, irq}, 32'd0);
    @(negedge clock);
    checkOutput("single_irq_c3", {31'd0, irq}, 32'd1);
    checkOutput("single_valid", {31'd0, statusValid}, 32'd1);
    checkOutput("single_desc", {28'd0, statusDesc}, 32'h5);
    checkOutput("single_flags", {28'd0, statusFlags}, 32'h1);
    pulseClr();
    checkOutput("single_clr_irq", {31'd0, irq}, 32'd0);
    checkOutput("single_clr_valid", {31'd0, statusValid}, 32'd0);
    checkOutput("single_clr_desc", {28'd0, statusDesc}, 32'd0);
    checkOutput("single_clr_flags", {28'd0, statusFlags}, 32'd0);

    // Masking: 0x31 dropped, 0x72 presented
    intMask = 4'h2;
    applyStimulus(8'h31, 1'b0);
    applyStimulus(8'h72, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("mask_drop_cnt", {24'd0, dropCnt}, 32'd1);
    checkOutput("mask_drop_noirq", {31'd0, irq}, 32'd0);
    waitIrq("mask_second", 10, cycles);
    checkOutput("mask_second_latency", cycles, 32'd3);
    checkOutput("mask_second_desc", {28'd0, statusDesc}, 32'h7);
    checkOutput("mask_second_flags", {28'd0, statusFlags}, 32'h2);
    checkOutput("mask_second_drop", {24'd0, dropCnt}, 32'd1);
    pulseClr();

    // Back-to-back presentations in FIFO order
    intMask = 4'hF;
    for (int i = 0; i < 3; i++) applyStimulus(b2bEvents[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitIrq("b2b_wait", 10, cycles);
      checkOutput("b2b_gap", cycles, 32'd3);
      checkOutput("b2b_desc", {28'd0, statusDesc}, {28'd0, b2bDesc[i]});
      checkOutput("b2b_flags", {28'd0, statusFlags}, {28'd0, b2bFlags[i]});
      pulseClr();
      checkOutput("b2b_clr_irq", {31'd0, irq}, 32'd0);
    end

    // Saturation of the drop counter
    dropCntClr = 1'b1;
    @(negedge clock);
    dropCntClr = 1'b0;
    checkOutput("sat_pre_clear", {24'd0, dropCnt}, 32'd0);
    intMask = 4'h0;
    for (int i = 0; i < 260; i++) applyStimulus(8'h0F, 1'b0);
    irqSeen = 1'b0;
    repeat (260 * 3 + 6) begin
      @(negedge clock);
      if (irq) irqSeen = 1'b1;
    end
    checkOutput("sat_no_irq", {31'd0, irqSeen}, 32'd0);
    checkOutput("sat_value", {24'd0, dropCnt}, 32'hFF);
    checkOutput("sat_fifo_drained", {31'd0, fifoEmpty}, 32'd1);

    // Clear in the same cycle as a drop wins
    applyStimulus(8'h01, 1'b0);
    repeat (2) @(negedge clock);
    dropCntClr = 1'b1;
    @(negedge clock);
    dropCntClr = 1'b0;
    checkOutput("clr_priority", {24'd0, dropCnt}, 32'd0);
    applyStimulus(8'h02, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("count_after_clr", {24'd0, dropCnt}, 32'd1);

    // ECC double-bit error on a presented event
    intMask = 4'hF;
    applyStimulus(8'h94, 1'b1);
    waitIrq("ecc_wait", 10, cycles);
    checkOutput("ecc_latency", cycles, 32'd3);
    checkOutput("ecc_set", {31'd0, eccErr}, 32'd1);
    checkOutput("ecc_desc", {28'd0, statusDesc}, 32'h9);
    checkOutput("ecc_flags", {28'd0, statusFlags}, 32'h4);
    intMask = 4'h0;
    @(negedge clock);
    checkOutput("ecc_mask_change_flags", {28'd0, statusFlags}, 32'h4);
    checkOutput("ecc_mask_change_irq", {31'd0, irq}, 32'd1);
    pulseClr();
    checkOutput("ecc_clr_irq", {31'd0, irq}, 32'd0);
    checkOutput("ecc_sticky", {31'd0, eccErr}, 32'd1);
    intMask = 4'hF;

    // Reset during PRESENT
    applyStimulus(8'h15, 1'b0);
    waitIrq("rst_mid_wait", 10, cycles);
    checkOutput("rst_mid_irq_before", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_mid_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_mid_valid", {31'd0, statusValid}, 32'd0);
    checkOutput("rst_mid_desc", {28'd0, statusDesc}, 32'd0);
    checkOutput("rst_mid_flags", {28'd0, statusFlags}, 32'd0);
    checkOutput("rst_mid_drop", {24'd0, dropCnt}, 32'd0);
    checkOutput("rst_mid_ecc", {31'd0, eccErr}, 32'd0);
    checkOutput("rst_mid_rden", {31'd0, fifoRdEn}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Stray clear in IDLE is ignored, then a fresh event has full latency
    pulseClr();
    checkOutput("stray_irq", {31'd0, irq}, 32'd0);
    checkOutput("stray_valid", {31'd0, statusValid}, 32'd0);
    checkOutput("stray_rden", {31'd0, fifoRdEn}, 32'd0);
    applyStimulus(8'h28, 1'b0);
    waitIrq("post_rst_wait", 10, cycles);
    checkOutput("post_rst_latency", cycles, 32'd3);
    checkOutput("post_rst_desc", {28'd0, statusDesc}, 32'h2);
    checkOutput("post_rst_flags", {28'd0, statusFlags}, 32'h8);
    pulseClr();
    checkOutput("post_rst_clr_irq", {31'd0, irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
